counter_sequencer: RTL

Control-side companion to the loadable up/down counter: drives the counter's 8-bit control word (load strobe, output enable, direction, 5-bit load data) and watches its 8-bit count readback. It accepts one command (start value, target), loads the counter, picks the count direction, and reports completion when the readback equals the target. When idle it parks the counter at 0 by holding load asserted.

---
 rtl/counter_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// Control-side sequencer for the loadable up/down counter: loads a start value, picks direction,
// and reports when the readback hits the target. Optional step timeout: define SEQ_TIMEOUT_EN.
module counter_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [4:0] cmd_start,
    input  logic [7:0] cmd_target,
    input  logic       cmd_show,
    input  logic       abort,
    input  logic [7:0] cnt_value,
    output logic [7:0] ctl_word,
    output logic       busy,
    output logic       done,
    output logic [1:0] status
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CTL_PARK = 8'h01;

    localparam logic [1:0] ST_HIT     = 2'b00;
    localparam logic [1:0] ST_ABORT   = 2'b01;
`ifdef SEQ_TIMEOUT_EN
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] target_q, target_nxt;
    logic [CW-1:0] ctl_nxt;
    logic          ready_nxt, busy_nxt, done_nxt;
    logic [1:0]    status_nxt;
    logic [CW-1:0] start_val;
    logic          dir_up;
    logic          finish;
`ifdef SEQ_TIMEOUT_EN
    logic [7:0]    step_q, step_nxt;
`endif

    // Counter loads {start, 2'b00}; direction is decided once at accept time
    assign start_val = CW'({cmd_start, 2'b00});
    assign dir_up    = (start_val <= cmd_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            target_q  <= '0;
            ctl_word  <= CTL_PARK;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= ST_HIT;
`ifdef SEQ_TIMEOUT_EN
            step_q    <= '0;
`endif
        end else begin
            state     <= state_nxt;
            target_q  <= target_nxt;
            ctl_word  <= ctl_nxt;
            cmd_ready <= ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            status    <= status_nxt;
`ifdef SEQ_TIMEOUT_EN
            step_q    <= step_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target_q;
        ctl_nxt    = ctl_word;
        done_nxt   = 1'b0;
        status_nxt = status;
        finish     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        step_nxt   = step_q;
`endif

        case (state)
            IDLE: begin
                ctl_nxt = CTL_PARK;
                if (cmd_valid && cmd_ready) begin
                    target_nxt = cmd_target;
                    ctl_nxt    = {cmd_start, dir_up, cmd_show, 1'b1};
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                ctl_nxt[0] = 1'b0;
                state_nxt  = RUN;
`ifdef SEQ_TIMEOUT_EN
                step_nxt   = '0;
`endif
            end
            RUN: begin
                // Priority: abort, then target match, then timeout
                if (abort) begin
                    finish     = 1'b1;
                    status_nxt = ST_ABORT;
                end else if (cnt_value == target_q) begin
                    finish     = 1'b1;
                    status_nxt = ST_HIT;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (step_q == 8'hFF) begin
                    finish     = 1'b1;
                    status_nxt = ST_TIMEOUT;
                end else begin
                    step_nxt = step_q + 8'd1;
                end
`endif
                if (finish) begin
                    state_nxt = IDLE;
                    ctl_nxt   = CTL_PARK;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                ctl_nxt   = CTL_PARK;
            end
        endcase

        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
    end

endmodule
